// File: rtl/instr_fetch_loader.sv
// Fetch front end: synchronizes and debounces the load button, then assembles a
// 16-bit instruction from two switch bytes and offers it over valid/ready.
module instr_fetch_loader #(
  parameter  int DB_CYCLES = 200000,
  localparam int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic [7:0]  sw,
  input  logic        flush,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [3:0]  opcode,
  output logic [11:0] operand,
  output logic        hi_pending,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_WAIT_LO = 2'd0,
    S_WAIT_HI = 2'd1,
    S_VALID   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync0_q, sync0_d;
  logic             sync1_q, sync1_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  state_t           state_q, state_d;
  logic             instr_valid_q, instr_valid_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [11:0]      operand_q, operand_d;
  logic             hi_pending_q, hi_pending_d;
  logic             overrun_q, overrun_d;

  // Synchronizer, debounce counter and press edge detect
  always_comb begin
    sync0_d    = btn_raw;
    sync1_d    = sync0_q;
    deb_d      = deb_q;
    cnt_d      = cnt_q;
    deb_prev_d = deb_q;
    // Any return to the accepted level discards a partial mismatch run.
    if (sync1_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = sync1_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    press_d = deb_q & ~deb_prev_q;
  end

  // Instruction assembly FSM
  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    opcode_d      = opcode_q;
    operand_d     = operand_q;
    hi_pending_d  = hi_pending_q;
    overrun_d     = overrun_q;
    if (flush) begin
      state_d       = S_WAIT_LO;
      instr_valid_d = 1'b0;
      opcode_d      = '0;
      operand_d     = '0;
      hi_pending_d  = 1'b0;
      overrun_d     = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_LO: begin
          if (press_q) begin
            opcode_d       = sw[3:0];
            operand_d[3:0] = sw[7:4];
            hi_pending_d   = 1'b1;
            state_d        = S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (press_q) begin
            operand_d[11:4] = sw;
            hi_pending_d    = 1'b0;
            instr_valid_d   = 1'b1;
            state_d         = S_VALID;
          end
        end
        S_VALID: begin
          // Held data is never overwritten; a press here is only recorded.
          if (press_q) begin
            overrun_d = 1'b1;
          end
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = S_WAIT_LO;
          end
        end
        default: begin
          state_d = S_WAIT_LO;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q       <= 1'b0;
      sync1_q       <= 1'b0;
      deb_q         <= 1'b0;
      deb_prev_q    <= 1'b0;
      cnt_q         <= '0;
      press_q       <= 1'b0;
      state_q       <= S_WAIT_LO;
      instr_valid_q <= 1'b0;
      opcode_q      <= '0;
      operand_q     <= '0;
      hi_pending_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sync0_q       <= sync0_d;
      sync1_q       <= sync1_d;
      deb_q         <= deb_d;
      deb_prev_q    <= deb_prev_d;
      cnt_q         <= cnt_d;
      press_q       <= press_d;
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      opcode_q      <= opcode_d;
      operand_q     <= operand_d;
      hi_pending_q  <= hi_pending_d;
      overrun_q     <= overrun_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign hi_pending  = hi_pending_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_instr_fetch_loader.sv
// Bench for instr_fetch_loader: directed scenarios plus randomized button/handshake
// traffic, compared every cycle against a window-based behavioural model.
module tb_instr_fetch_loader;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_raw = 1'b0;
  logic [7:0]  sw = 8'h00;
  logic        flush = 1'b0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic        hi_pending;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;

  // Model: last DB+2 button samples, accepted level, press delay line, instruction state
  bit          bq[$];
  bit          m_deb;
  bit          r1, r2;
  bit          m_valid, m_hi, m_ovr;
  logic [3:0]  m_op;
  logic [11:0] m_opnd;

  instr_fetch_loader #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw(sw), .flush(flush),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .opcode(opcode),
    .operand(operand), .hi_pending(hi_pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    bq.delete();
    for (int i = 0; i < DB + 2; i++) bq.push_back(1'b0);
    m_deb = 0; r1 = 0; r2 = 0;
    m_valid = 0; m_hi = 0; m_ovr = 0; m_op = '0; m_opnd = '0;
  endtask

  // Level flips when the synchronized button disagreed with it on DB consecutive edges;
  // the synchronized value seen at edge n is the button sampled at edge n-2.
  task automatic model_edge();
    bit press_in, rose, all_diff;
    press_in = r2;
    r2 = r1;
    bq.push_back(btn_raw);
    void'(bq.pop_front());
    all_diff = 1'b1;
    for (int i = 0; i < DB; i++) if (bq[i] == m_deb) all_diff = 1'b0;
    rose = 1'b0;
    if (all_diff) begin
      rose = !m_deb;
      m_deb = !m_deb;
    end
    r1 = rose;
    if (flush) begin
      m_valid = 0; m_hi = 0; m_ovr = 0; m_op = '0; m_opnd = '0;
    end else if (m_valid) begin
      if (press_in) m_ovr = 1;
      if (instr_ready) m_valid = 0;
    end else if (m_hi) begin
      if (press_in) begin
        m_opnd[11:4] = sw; m_hi = 0; m_valid = 1;
      end
    end else if (press_in) begin
      m_op = sw[3:0]; m_opnd[3:0] = sw[7:4]; m_hi = 1;
    end
  endtask

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] dut_vec();
    return {instr_valid, opcode, operand, hi_pending, overrun};
  endfunction

  function automatic logic [18:0] model_vec();
    return {m_valid, m_op, m_opnd, m_hi, m_ovr};
  endfunction

  task automatic step(input bit b, input logic [7:0] s, input bit rdy, input bit fl,
                      input string tag);
    btn_raw = b; sw = s; instr_ready = rdy; flush = fl;
    @(posedge clk);
    model_edge();
    #1 check(tag, dut_vec(), model_vec());
  endtask

  task automatic press(input logic [7:0] s, input bit rdy, input string tag);
    repeat (8) step(1'b1, s, rdy, 1'b0, tag);
    repeat (8) step(1'b0, s, rdy, 1'b0, tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset", dut_vec(), 19'h0);
    check("reset_model", dut_vec(), model_vec());
    #2 rst = 1'b0;

    // Glitch shorter than the debounce window
    repeat (3) step(1'b1, 8'h00, 1'b0, 1'b0, "glitch");
    repeat (10) step(1'b0, 8'h00, 1'b0, 1'b0, "glitch");
    check("glitch_idle", dut_vec(), 19'h0);

    // First byte: capture lands on the eighth edge after the button is first sampled
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'hA5, 1'b1, 1'b0, "lat");
      if (i == 6) check("lat_before", {18'h0, hi_pending}, 19'h0);
      if (i == 7) check("lat_capture", {18'h0, hi_pending}, 19'h1);
    end
    repeat (8) step(1'b0, 8'hA5, 1'b1, 1'b0, "lat_rel");
    press(8'h3C, 1'b1, "hs_ready");
    check("hs_done", {instr_valid, opcode, operand}, {1'b0, 4'h5, 12'h3CA});

    // Backpressure and overrun
    press(8'hA5, 1'b0, "bp_lo");
    press(8'h3C, 1'b0, "bp_hi");
    check("bp_held", {instr_valid, opcode, operand}, {1'b1, 4'h5, 12'h3CA});
    press(8'h5A, 1'b0, "bp_third");
    check("bp_overrun", {instr_valid, opcode, operand, overrun}, {1'b1, 4'h5, 12'h3CA, 1'b1});
    step(1'b0, 8'h5A, 1'b1, 1'b0, "bp_accept");
    check("bp_drop", {17'h0, instr_valid, overrun}, 19'h1);

    // Bouncy press yields one capture
    for (int i = 0; i < 10; i++) step(1'(i % 2), 8'h77, 1'b0, 1'b0, "bounce");
    repeat (8) step(1'b1, 8'h77, 1'b0, 1'b0, "bounce_hold");
    repeat (8) step(1'b0, 8'h77, 1'b0, 1'b0, "bounce_rel");
    check("bounce_one", {instr_valid, opcode, hi_pending}, {1'b0, 4'h7, 1'b1});

    // Flush behaviour
    step(1'b0, 8'h00, 1'b0, 1'b1, "flush0");
    press(8'hFF, 1'b0, "fl_lo");
    check("fl_pending", {opcode, hi_pending}, {4'hF, 1'b1});
    step(1'b0, 8'hFF, 1'b0, 1'b1, "flush1");
    check("fl_clear", dut_vec(), 19'h0);
    press(8'h12, 1'b0, "fl_a");
    press(8'h34, 1'b0, "fl_b");
    check("fl_data", {instr_valid, opcode, operand}, {1'b1, 4'h2, 12'h341});
    step(1'b0, 8'h34, 1'b1, 1'b0, "fl_accept");

    // Async reset in S_WAIT_HI with button held across release
    press(8'h9C, 1'b0, "rs_lo");
    repeat (3) step(1'b1, 8'h9C, 1'b0, 1'b0, "rs_hold");
    #2 rst = 1'b1;
    #1 check("rs_async", dut_vec(), 19'h0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) step(1'b1, 8'hE7, 1'b0, 1'b0, "rs_after");
    repeat (8) step(1'b0, 8'hE7, 1'b0, 1'b0, "rs_rel");
    check("rs_low_only", {instr_valid, opcode, hi_pending}, {1'b0, 4'h7, 1'b1});

    // Randomized traffic
    for (int r = 0; r < 300; r++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++)
        step(lvl, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0),
             "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
